axis_result_fifo: RTL and testbench
===================================

Name: axis_result_fifo

Overview:
- Output buffer placed directly downstream of the systolic-array/CORDIC top.
- The array's m00 AXIS master has no tready, so it cannot be backpressured. This block stores each result beat (LANES x OUT_WIDTH plus tlast) in a FIFO.
- It re-presents the beats as a fully handshaked AXIS master toward the DMA.
- It reports overflow and counts delivered frames so software can detect lost results.

Parameters:
- LANES, 4, number of result lanes per beat
- OUT_WIDTH, 16, bits per lane
- DEPTH, 16, FIFO entries; must be a power of 2 and >= 4
- CNT_WIDTH, 16, width of the frame and drop counters

Ports:
- s00_axis_aclk  in  1  single clock for both interfaces
- s00_axis_aresetn  in  1  synchronous active-low reset
- s00_axis_tdata  in  LANES*OUT_WIDTH  result beat from the array
- s00_axis_tvalid  in  1  beat present; upstream never waits
- s00_axis_tlast  in  1  last beat of a result frame
- s00_axis_tready  out  1  space-available indicator (informational; upstream ignores it)
- m00_axis_tdata  out  LANES*OUT_WIDTH  head-of-FIFO data
- m00_axis_tvalid  out  1  FIFO non-empty
- m00_axis_tready  in  1  downstream accept
- m00_axis_tlast  out  1  head-entry tlast
- ovf_clr  in  1  one-cycle pulse; clears overflow and drop_count
- overflow  out  1  sticky: at least one beat was dropped
- drop_count  out  CNT_WIDTH  number of dropped beats, saturating
- frame_count  out  CNT_WIDTH  number of tlast beats delivered downstream, wrapping

Behaviour:
- Storage:
  - DEPTH x (LANES*OUT_WIDTH+1) register array.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Definitions:
  - pop = m00_axis_tvalid & m00_axis_tready.
  - push = s00_axis_tvalid & (count<DEPTH | pop).
  - drop = s00_axis_tvalid & ~push.
- Full plus pop in the same cycle: the write is accepted, count stays at DEPTH, no drop.
- Empty plus push: no bypass. Data appears on m00 in the cycle after the write edge, so latency is 1 cycle.
- Outputs:
  - m00_axis_tvalid = (count != 0).
  - m00_axis_tdata and m00_axis_tlast = mem[rd_ptr], first-word fall-through.
  - Data is held stable while tvalid=1 and tready=0.
- s00_axis_tready = (count < DEPTH), combinational from registered count only. It has no path from m00_axis_tready.
- Drop handling:
  - The dropped beat is discarded, including its tlast.
  - overflow is set on the next edge.
  - drop_count increments and saturates at all-ones.
- ovf_clr:
  - On the next edge, overflow=0 and drop_count=0.
  - If drop and ovf_clr occur in the same cycle, drop wins: overflow=1, drop_count=1.
- frame_count increments on each pop whose m00_axis_tlast=1 and wraps at 2^CNT_WIDTH.
- Reset: when s00_axis_aresetn=0 at a clock edge:
  - wr_ptr, rd_ptr, count, overflow, drop_count and frame_count are cleared to 0.
  - m00_axis_tvalid=0 and s00_axis_tready=1 from the following cycle.
  - FIFO contents are not cleared but are unreachable.
  - Reset mid-frame discards all buffered beats; there is no partial-frame recovery.
- Inputs are ignored while reset is asserted.

Optional Feature:
- Macro RESULT_FIFO_STATS_EN.
- Defined: adds two output ports.
  - max_level (log2(DEPTH)+1 bits): high-water mark of count since reset or since ovf_clr.
  - beat_count (CNT_WIDTH, wrapping): total pops.
  - Both are reset to 0 by aresetn. max_level is also cleared by ovf_clr, then reloads from the current count on the next edge.
- Not defined: both ports and their logic are absent, and the rest of the behaviour is identical.

Test Plan:
- One 12-beat frame, m00_axis_tready=1, s_tvalid continuous:
  - m_tvalid rises 1 cycle after the first beat.
  - 12 beats come out in order, with tlast only on beat 12.
  - frame_count=1, overflow=0.
- m00_axis_tready=0 while 17 beats are pushed:
  - s00_axis_tready falls after beat 16; beat 17 is dropped.
  - overflow=1, drop_count=1.
  - Releasing tready yields beats 1..16 intact.
  - ovf_clr then gives overflow=0 and drop_count=0.
- FIFO full (16 entries), then push and pop in the same cycle: write accepted, count stays 16, no drop, and the output order is preserved.
- Five entries buffered mid-frame, then aresetn=0 for one edge:
  - Next cycle m_tvalid=0, s_tready=1, counters 0.
  - A following 12-beat frame is delivered cleanly.
- Two back-to-back 12-beat frames with m_tready toggling 1/0 every cycle:
  - 24 beats delivered; tlast on the 12th and 24th; frame_count=2.
  - tdata is stable during stalls.
- With RESULT_FIFO_STATS_EN defined and the scenario 2 stimulus: max_level=16 and beat_count=16 after the drain.

Source files
------------

// File: rtl/axis_result_fifo.sv
// rtl/axis_result_fifo.sv - result-beat FIFO that adds backpressure between the array and the DMA
//
// Purpose:
//   The array's m00 AXIS master has no tready, so it cannot be stalled.
//   This block buffers each result beat ({tlast, tdata}) in a first-word
//   fall-through FIFO. It re-presents the beats as a fully handshaked AXIS
//   master toward the DMA. Beats that arrive while the FIFO is full are
//   dropped, and the drop is reported through a sticky flag and a saturating
//   counter. Frames that are delivered downstream are counted.
//
// Ports:
//   s00_axis_aclk     single clock for both interfaces
//   s00_axis_aresetn  synchronous active-low reset
//   s00_axis_tdata    result beat from the array (LANES*OUT_WIDTH bits)
//   s00_axis_tvalid   beat present; upstream never waits
//   s00_axis_tlast    last beat of a result frame
//   s00_axis_tready   space available (informational only)
//   m00_axis_tdata    head-of-FIFO data
//   m00_axis_tvalid   FIFO non-empty
//   m00_axis_tready   downstream accept
//   m00_axis_tlast    head-entry tlast
//   ovf_clr           one-cycle pulse; clears overflow and drop_count
//   overflow          sticky: at least one beat was dropped
//   drop_count        dropped beats, saturating
//   frame_count       tlast beats delivered downstream, wrapping
//
// Optional feature (macro RESULT_FIFO_STATS_EN):
//   max_level         high-water mark of the fill level since reset/ovf_clr
//   beat_count        total beats delivered downstream, wrapping
//
// DEPTH must be a power of two and at least 4.

module axis_result_fifo #(
  parameter int LANES     = 4,
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         s00_axis_aclk,
  input  logic                         s00_axis_aresetn,
  input  logic [LANES*OUT_WIDTH-1:0]   s00_axis_tdata,
  input  logic                         s00_axis_tvalid,
  input  logic                         s00_axis_tlast,
  output logic                         s00_axis_tready,
  output logic [LANES*OUT_WIDTH-1:0]   m00_axis_tdata,
  output logic                         m00_axis_tvalid,
  input  logic                         m00_axis_tready,
  output logic                         m00_axis_tlast,
  input  logic                         ovf_clr,
  output logic                         overflow,
  output logic [CNT_WIDTH-1:0]         drop_count,
  output logic [CNT_WIDTH-1:0]         frame_count
`ifdef RESULT_FIFO_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]       max_level,
  output logic [CNT_WIDTH-1:0]         beat_count
`endif
);

  localparam int DW = LANES * OUT_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]          CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [DW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [DW:0]   head;
  logic          pop;
  logic          push;
  logic          drop;

  // First-word fall-through: the head entry is always visible on m00.
  // It stays stable during a stall because rd_ptr only moves on pop.
  assign head            = mem[rd_ptr];
  assign m00_axis_tdata  = head[DW-1:0];
  assign m00_axis_tlast  = head[DW];
  assign m00_axis_tvalid = (count != '0);

  // s00_axis_tready is derived from the registered count only. This keeps it
  // free of any combinational path from m00_axis_tready.
  assign s00_axis_tready = (count < CNT_FULL);

  assign pop  = m00_axis_tvalid & m00_axis_tready;
  // When the FIFO is full, a simultaneous pop frees the slot that the write
  // lands in, so the beat is still accepted.
  assign push = s00_axis_tvalid & (s00_axis_tready | pop);
  assign drop = s00_axis_tvalid & ~push;

  // Storage is never reset. Entries become unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_aresetn && push) begin
      mem[wr_ptr] <= {s00_axis_tlast, s00_axis_tdata};
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Drop takes priority over ovf_clr. A drop in the clearing cycle leaves
  // overflow set and drop_count at exactly one.
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr) begin
        drop_count <= CNT_WIDTH'(1);
      end else if (drop_count != CNT_MAX) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end else if (ovf_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      frame_count <= '0;
    end else if (pop && m00_axis_tlast) begin
      frame_count <= frame_count + CNT_WIDTH'(1);
    end
  end

`ifdef RESULT_FIFO_STATS_EN
  // The high-water mark tracks the registered count. After ovf_clr it
  // restarts from zero and picks up the current level on the following edge.
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      max_level <= '0;
    end else if (ovf_clr) begin
      max_level <= '0;
    end else if (count > max_level) begin
      max_level <= count;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      beat_count <= '0;
    end else if (pop) begin
      beat_count <= beat_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_axis_result_fifo.sv
// tb/tb_axis_result_fifo.sv - self-checking bench for axis_result_fifo
module tb_axis_result_fifo;

  localparam int LANES     = 4;
  localparam int OUT_WIDTH = 16;
  localparam int DEPTH     = 16;
  localparam int CNT_WIDTH = 16;
  localparam int DW        = LANES * OUT_WIDTH;

  logic                 clk;
  logic                 resetn;
  logic [DW-1:0]        s_tdata;
  logic                 s_tvalid;
  logic                 s_tlast;
  logic                 s_tready;
  logic [DW-1:0]        m_tdata;
  logic                 m_tvalid;
  logic                 m_tready;
  logic                 m_tlast;
  logic                 ovf_clr;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] drop_count;
  logic [CNT_WIDTH-1:0] frame_count;
`ifdef RESULT_FIFO_STATS_EN
  logic [$clog2(DEPTH):0] max_level;
  logic [CNT_WIDTH-1:0]   beat_count;
`endif

  axis_result_fifo #(
    .LANES(LANES), .OUT_WIDTH(OUT_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(resetn),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tready (s_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tready (m_tready),
    .m00_axis_tlast  (m_tlast),
    .ovf_clr         (ovf_clr),
    .overflow        (overflow),
    .drop_count      (drop_count),
    .frame_count     (frame_count)
`ifdef RESULT_FIFO_STATS_EN
    ,
    .max_level       (max_level),
    .beat_count      (beat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of {tlast, tdata} plus plain counters.
  logic [DW:0] q[$];
  logic        m_ovf;
  int          m_drop;
  int          m_fc;
  int          m_beats;
  int          m_max;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("m_tvalid", 128'(m_tvalid), 128'(q.size() != 0));
    chk("s_tready", 128'(s_tready), 128'(q.size() < DEPTH));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("drop_count", 128'(drop_count), 128'(m_drop));
    chk("frame_count", 128'(frame_count), 128'(m_fc % 65536));
    if (q.size() != 0) begin
      chk("head", 128'({m_tlast, m_tdata}), 128'(q[0]));
    end
`ifdef RESULT_FIFO_STATS_EN
    chk("max_level", 128'(max_level), 128'(m_max));
    chk("beat_count", 128'(beat_count), 128'(m_beats % 65536));
`endif
  endtask

  // Drive one cycle's inputs, advance the model across the edge, then check
  // the DUT 1 time unit after the edge.
  task automatic cycle(input logic rn, input logic tv, input logic tl, input logic tr,
                       input logic clr, input logic [DW-1:0] d);
    bit p_pop, p_push, p_drop;
    int lvl;
    resetn = rn; s_tvalid = tv; s_tlast = tl; m_tready = tr; ovf_clr = clr; s_tdata = d;
    lvl    = q.size();
    p_pop  = (lvl != 0) && tr;
    p_push = tv && ((lvl < DEPTH) || p_pop);
    p_drop = tv && !p_push;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      m_ovf = 1'b0; m_drop = 0; m_fc = 0; m_beats = 0; m_max = 0;
    end else begin
      if (clr) m_max = 0;
      else if (lvl > m_max) m_max = lvl;
      if (p_pop) begin
        if (q[0][DW]) m_fc++;
        m_beats++;
        void'(q.pop_front());
      end
      if (p_push) q.push_back({tl, d});
      if (p_drop) begin
        m_ovf  = 1'b1;
        m_drop = clr ? 1 : ((m_drop == 65535) ? 65535 : m_drop + 1);
      end else if (clr) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
    end
    #1;
    model_check();
  endtask

  function automatic logic [DW-1:0] beat_data(input int tag, input int i);
    return {16'(tag), 16'(i), 16'hA5C3 ^ 16'(i * 7), 16'(tag * 31 + i)};
  endfunction

  typedef struct {
    logic rn, tv, tl, tr, clr;
    logic [DW-1:0] d;
    logic e_mv, e_sr, e_ovf;
    int   e_drop, e_fc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rn, tv, tl, tr, clr, input logic [DW-1:0] d,
                         input logic e_mv, e_sr, e_ovf, input int e_drop, e_fc);
    vec_t v;
    v.rn = rn; v.tv = tv; v.tl = tl; v.tr = tr; v.clr = clr; v.d = d;
    v.e_mv = e_mv; v.e_sr = e_sr; v.e_ovf = e_ovf; v.e_drop = e_drop; v.e_fc = e_fc;
    vecs.push_back(v);
  endtask

  // Drain with m_tready high, bounded; an incomplete drain counts as a failure.
  task automatic drain(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      cycle(1, 0, 0, 1, 0, '0);
      n++;
    end
    chk("drain_done", 128'(m_tvalid), 128'(0));
  endtask

  initial begin
    logic [DW-1:0] held;
    bit            stall;
    int            drain_row;
    int            base;

    resetn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    ovf_clr = 1'b0; s_tdata = '0;
    m_ovf = 1'b0; m_drop = 0; m_fc = 0; m_beats = 0; m_max = 0;

    // Table: reset, 17 beats into a stalled FIFO, drain, then ovf_clr.
    add_vec(0, 1, 1, 1, 1, beat_data(9, 9), 0, 1, 0, 0, 0);
    for (int i = 1; i <= 17; i++)
      add_vec(1, 1, (i == 17), 0, 0, beat_data(2, i), 1, (i < 16), (i == 17), (i == 17) ? 1 : 0, 0);
    for (int j = 1; j <= 16; j++)
      add_vec(1, 0, 0, 1, 0, '0, (j < 16), 1, 1, 1, 0);
    drain_row = vecs.size() - 1;
    add_vec(1, 0, 0, 0, 1, '0, 0, 1, 0, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      cycle(vecs[k].rn, vecs[k].tv, vecs[k].tl, vecs[k].tr, vecs[k].clr, vecs[k].d);
      chk("vec_mv", 128'(m_tvalid), 128'(vecs[k].e_mv));
      chk("vec_sr", 128'(s_tready), 128'(vecs[k].e_sr));
      chk("vec_ovf", 128'(overflow), 128'(vecs[k].e_ovf));
      chk("vec_drop", 128'(drop_count), 128'(vecs[k].e_drop));
      chk("vec_fc", 128'(frame_count), 128'(vecs[k].e_fc));
      if (k >= 1 && k <= 16)
        chk("vec_head", 128'(m_tdata), 128'(beat_data(2, 1)));
`ifdef RESULT_FIFO_STATS_EN
      if (k == drain_row) begin
        chk("stats_max", 128'(max_level), 128'(16));
        chk("stats_beats", 128'(beat_count), 128'(16));
      end
`endif
    end

    // A: one 12-beat frame with tready held high.
    for (int i = 1; i <= 12; i++) begin
      cycle(1, 1, (i == 12), 1, 0, beat_data(3, i));
      if (i == 1) chk("A_latency", 128'(m_tvalid), 128'(1));
    end
    drain(4);
    chk("A_fc", 128'(frame_count), 128'(1));
    chk("A_ovf", 128'(overflow), 128'(0));

    // B: full FIFO, then push and pop in the same cycle.
    for (int i = 1; i <= 16; i++) cycle(1, 1, 0, 0, 0, beat_data(4, i));
    cycle(1, 1, 0, 1, 0, beat_data(4, 17));
    chk("B_sready", 128'(s_tready), 128'(0));
    chk("B_drop", 128'(drop_count), 128'(0));
    chk("B_ovf", 128'(overflow), 128'(0));
    chk("B_head", 128'(m_tdata), 128'(beat_data(4, 2)));
    drain(20);

    // C: reset with five beats of a partial frame buffered.
    for (int i = 1; i <= 5; i++) cycle(1, 1, 0, 0, 0, beat_data(5, i));
    cycle(0, 1, 1, 1, 0, beat_data(5, 6));
    chk("C_mv", 128'(m_tvalid), 128'(0));
    chk("C_sr", 128'(s_tready), 128'(1));
    chk("C_fc", 128'(frame_count), 128'(0));
    for (int i = 1; i <= 12; i++) cycle(1, 1, (i == 12), 1, 0, beat_data(6, i));
    drain(4);
    chk("C_fc_after", 128'(frame_count), 128'(1));

    // D: two back-to-back frames with m_tready toggling every cycle.
    cycle(0, 0, 0, 0, 0, '0);
    for (int i = 1; i <= 24; i++) begin
      stall = m_tvalid && !(i % 2 == 1);
      held  = m_tdata;
      cycle(1, 1, (i == 12 || i == 24), (i % 2 == 1), 0, beat_data(7, i));
      if (stall) chk("D_stable", 128'(m_tdata), 128'(held));
    end
    for (int n = 0; n < 60 && q.size() != 0; n++) begin
      stall = m_tvalid && (n % 2 == 1);
      held  = m_tdata;
      cycle(1, 0, 0, (n % 2 == 0), 0, '0);
      if (stall) chk("D_stable", 128'(m_tdata), 128'(held));
    end
    chk("D_empty", 128'(m_tvalid), 128'(0));
    chk("D_fc", 128'(frame_count), 128'(2));
    chk("D_beats", 128'(m_beats), 128'(24));

    // E: randomized traffic against the model.
    base = 0;
    for (int n = 0; n < 600; n++) begin
      cycle(1, ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) < 5), ($urandom_range(0, 29) == 0),
            {$urandom, $urandom});
      base++;
    end
    drain(DEPTH + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
